// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC pad packet receiver.
package adc_pkt_pkg;

   localparam int         DATA_W     = 18;
   localparam logic [1:0] HDR_MARKER = 2'b10;

   typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER, GAP} state_e;

   typedef struct packed {
      logic              err;
      logic              eop;
      logic              sop;
      logic [DATA_W-1:0] data;
   } rx_entry_t;

   // Builds one output-FIFO entry from its fields.
   function automatic rx_entry_t mk_entry(input logic err, input logic eop, input logic sop,
                                          input logic [DATA_W-1:0] data);
      rx_entry_t e;
      e.err  = err;
      e.eop  = eop;
      e.sop  = sop;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/adc_pkt_rx_if.sv
// Payload stream out of the receiver: one word per transfer, valid/ready handshake.
interface adc_pkt_rx_if;
   import adc_pkt_pkg::*;

   logic [DATA_W-1:0] data;
   logic              sop;
   logic              eop;
   logic              err;
   logic              valid;
   logic              ready;

   modport master (output data, sop, eop, err, valid, input ready);
   modport slave  (input data, sop, eop, err, valid, output ready);
endinterface

// File: rtl/adc_pkt_rx_fifo.sv
// First-word-fall-through FIFO. A push while full is accepted only if the same
// cycle pops; otherwise it is dropped and reported on drop.
module adc_pkt_rx_fifo #(
   parameter int  DEPTH   = 16,
   parameter type entry_t = logic
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   wr_en,
   input  entry_t wr_data,
   output logic   full,
   output logic   drop,
   input  logic   rd_en,
   output entry_t rd_data,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_wr;
   logic            do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign drop    = wr_en & full & ~do_rd;
   assign rd_data = mem[rd_ptr];

   // Storage write.
   // NOTE: the array is not reset; count alone says which slots hold data, so stale contents are never presented.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy tracking.
   // NOTE: non-blocking assignments make every flop update from pre-edge values; blocking ones would chain within the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/adc_pkt_rx.sv
// ADC pad packet receiver: oversamples CLK_RD, de-frames header/payload/trailer
// packets, checks them and streams payload words out through a FIFO.
module adc_pkt_rx
   import adc_pkt_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_en,
   input  logic [7:0]        cfg_idle_len,
   input  logic              status_clr,
   input  logic              adc_clk_rd,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_data_valid,
   adc_pkt_rx_if.master      out,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              hdr_err,
   output logic              seq_err,
   output logic              crc_err,
   output logic              len_err,
   output logic              gap_err,
   output logic              ovf_err,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
   localparam logic [1:0] ST_TRAILER = TRAILER;
   localparam logic [1:0] ST_GAP     = GAP;

   logic [1:0]        clk_rd_sync;
   logic              clk_rd_q;
   logic              strobe;
   logic [DATA_W-1:0] data_s1, data_s2;
   logic              vld_s1, vld_s2;

   logic [1:0]        state;
   logic [7:0]        seq_lat, len_lat, cnt, gap_cnt, seq_ref;
   logic              ref_vld, skid_vld, first;
   logic [DATA_W-1:0] xor_acc, skid_data;
   logic              push_vld;
   rx_entry_t         push_ent;
   logic              ev_hdr, ev_seq, ev_crc, ev_len, ev_gap, ev_lost;

   logic              hdr_ok, in_hdr, abort, seq_bad, crc_bad;
   logic [7:0]        cnt_nxt;

   rx_entry_t         wr_ent, rd_ent;
   logic              fifo_full, fifo_empty, drop, pkt_ovf;
   logic              eop_done, final_err, pkt_inc, err_inc;

   // Two-flop synchronisers on all pads; strobe fires on the synchronised CLK_RD rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_rd_sync <= '0;
         clk_rd_q    <= 1'b0;
         strobe      <= 1'b0;
         data_s1     <= '0;
         data_s2     <= '0;
         vld_s1      <= 1'b0;
         vld_s2      <= 1'b0;
      end else begin
         clk_rd_sync <= {clk_rd_sync[0], adc_clk_rd};
         clk_rd_q    <= clk_rd_sync[1];
         strobe      <= clk_rd_sync[1] & ~clk_rd_q;
         data_s1     <= adc_data;
         data_s2     <= data_s1;
         vld_s1      <= adc_data_valid;
         vld_s2      <= vld_s1;
      end
   end

   // Word classification for the current strobe.
   always_comb begin
      hdr_ok  = (data_s2[DATA_W-1 -: 2] == HDR_MARKER) && (data_s2[7:0] != 8'd0);
      in_hdr  = strobe && vld_s2 && (state == ST_IDLE || state == ST_GAP);
      abort   = strobe && !vld_s2 && (state == ST_PAYLOAD || state == ST_TRAILER);
      seq_bad = ref_vld && (seq_lat != seq_ref + 8'd1);
      crc_bad = (data_s2 != xor_acc);
      cnt_nxt = cnt + 8'd1;
   end

   // De-framing FSM; emits registered pushes and one-cycle check events.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         seq_lat   <= '0;
         len_lat   <= '0;
         cnt       <= '0;
         gap_cnt   <= '0;
         seq_ref   <= '0;
         ref_vld   <= 1'b0;
         skid_vld  <= 1'b0;
         first     <= 1'b0;
         xor_acc   <= '0;
         skid_data <= '0;
         push_vld  <= 1'b0;
         push_ent  <= '0;
         {ev_hdr, ev_seq, ev_crc, ev_len, ev_gap, ev_lost} <= '0;
      end else begin
         push_vld <= 1'b0;
         {ev_hdr, ev_seq, ev_crc, ev_len, ev_gap, ev_lost} <= '0;
         if (!rx_en) begin
            state    <= ST_IDLE;
            skid_vld <= 1'b0;
            ref_vld  <= 1'b0;
         end else if (in_hdr) begin
            ev_gap <= (state == ST_GAP) && (cfg_idle_len != 8'd0);
            if (hdr_ok) begin
               seq_lat  <= data_s2[15:8];
               len_lat  <= data_s2[7:0];
               cnt      <= '0;
               xor_acc  <= '0;
               skid_vld <= 1'b0;
               first    <= 1'b1;
               state    <= ST_PAYLOAD;
            end else begin
               ev_hdr  <= 1'b1;
               gap_cnt <= '0;
               state   <= ST_GAP;
            end
         end else if (abort) begin
            // Short packet: close it with the held word, or just count it if none was held.
            ev_len <= 1'b1;
            if (skid_vld) begin
               push_vld <= 1'b1;
               push_ent <= mk_entry(1'b1, 1'b1, first, skid_data);
            end else begin
               ev_lost <= 1'b1;
            end
            skid_vld <= 1'b0;
            gap_cnt  <= '0;
            state    <= ST_GAP;
         end else begin
            case (state)
               ST_PAYLOAD: if (strobe) begin
                  xor_acc   <= xor_acc ^ data_s2;
                  skid_data <= data_s2;
                  skid_vld  <= 1'b1;
                  cnt       <= cnt_nxt;
                  if (skid_vld) begin
                     push_vld <= 1'b1;
                     push_ent <= mk_entry(1'b0, 1'b0, first, skid_data);
                     first    <= 1'b0;
                  end
                  if (cnt_nxt == len_lat) state <= ST_TRAILER;
               end
               ST_TRAILER: if (strobe) begin
                  push_vld <= 1'b1;
                  push_ent <= mk_entry(crc_bad | seq_bad, 1'b1, first, skid_data);
                  ev_crc   <= crc_bad;
                  ev_seq   <= seq_bad;
                  seq_ref  <= seq_lat;
                  ref_vld  <= 1'b1;
                  skid_vld <= 1'b0;
                  gap_cnt  <= '0;
                  state    <= ST_GAP;
               end
               ST_GAP: begin
                  if (cfg_idle_len == 8'd0) begin
                     state <= ST_IDLE;
                  end else if (strobe) begin
                     gap_cnt <= gap_cnt + 8'd1;
                     if (({1'b0, gap_cnt} + 9'd1) >= {1'b0, cfg_idle_len}) state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // A packet that lost any word to overflow gets its eop entry marked bad.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      wr_ent     = push_ent;
      wr_ent.err = push_ent.err | (push_ent.eop & pkt_ovf);
   end

   adc_pkt_rx_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (rx_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_vld),
      .wr_data (wr_ent),
      .full    (fifo_full),
      .drop    (drop),
      .rd_en   (out.ready),
      .rd_data (rd_ent),
      .empty   (fifo_empty)
   );

   // Remembers an overflow drop until the packet's eop push.
   always_ff @(posedge clk) begin
      if (rst)                          pkt_ovf <= 1'b0;
      else if (push_vld & push_ent.eop) pkt_ovf <= 1'b0;
      else if (drop)                    pkt_ovf <= 1'b1;
      else if (!rx_en)                  pkt_ovf <= 1'b0;
   end

   assign eop_done  = push_vld & push_ent.eop;
   assign final_err = wr_ent.err | drop;
   assign pkt_inc   = eop_done & ~final_err;
   assign err_inc   = (eop_done & final_err) | ev_hdr | ev_lost;

   // Packet counters and sticky flags; a clear wins over a same-cycle set.
   always_ff @(posedge clk) begin
      if (rst || status_clr) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
         {hdr_err, seq_err, crc_err, len_err, gap_err, ovf_err} <= '0;
      end else begin
         pkt_cnt <= pkt_cnt + CNT_W'(pkt_inc);
         if (err_inc && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
         hdr_err <= hdr_err | ev_hdr;
         seq_err <= seq_err | ev_seq;
         crc_err <= crc_err | ev_crc;
         len_err <= len_err | ev_len;
         gap_err <= gap_err | ev_gap;
         ovf_err <= ovf_err | drop;
      end
   end

   assign out.valid = ~fifo_empty;
   assign out.data  = fifo_empty ? '0 : rd_ent.data;
   assign out.sop   = ~fifo_empty & rd_ent.sop;
   assign out.eop   = ~fifo_empty & rd_ent.eop;
   assign out.err   = ~fifo_empty & rd_ent.err;
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_pkt_rx.sv
// Bench for adc_pkt_rx: drives framed packets on the pad pins with CLK_RD = clk/8
// and compares the output stream against a scoreboard queue.
module tb_adc_pkt_rx;
   import adc_pkt_pkg::*;

   logic              clk = 1'b0;
   logic              rst, rx_en, status_clr;
   logic [7:0]        cfg_idle_len;
   logic              adc_clk_rd, adc_data_valid;
   logic [DATA_W-1:0] adc_data;
   logic [15:0]       pkt_cnt, err_cnt;
   logic              hdr_err, seq_err, crc_err, len_err, gap_err, ovf_err, busy;

   adc_pkt_rx_if out_if ();

   adc_pkt_rx #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_en          (rx_en),
      .cfg_idle_len   (cfg_idle_len),
      .status_clr     (status_clr),
      .adc_clk_rd     (adc_clk_rd),
      .adc_data       (adc_data),
      .adc_data_valid (adc_data_valid),
      .out            (out_if),
      .pkt_cnt        (pkt_cnt),
      .err_cnt        (err_cnt),
      .hdr_err        (hdr_err),
      .seq_err        (seq_err),
      .crc_err        (crc_err),
      .len_err        (len_err),
      .gap_err        (gap_err),
      .ovf_err        (ovf_err),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int                n_tests = 0;
   int                n_fail  = 0;
   rx_entry_t         sb [$];
   logic [DATA_W-1:0] pl [$];
   int                exp_pkt = 0;
   int                exp_err = 0;
   logic [7:0]        exp_ref = '0;
   bit                exp_ref_vld = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: a transfer seen on the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_if.valid && out_if.ready) begin
         rx_entry_t got;
         got.err  = out_if.err;
         got.eop  = out_if.eop;
         got.sop  = out_if.sop;
         got.data = out_if.data;
         if (sb.size() == 0) check("extra_word", {11'd0, got}, 32'hFFFF_FFFF);
         else                check("word", {11'd0, got}, {11'd0, sb.pop_front()});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One CLK_RD period: data launched on the falling edge, captured on the rising edge.
   task automatic send_word(input bit v, input logic [DATA_W-1:0] d);
      adc_clk_rd     = 1'b0;
      adc_data       = d;
      adc_data_valid = v;
      tick(4);
      adc_clk_rd     = 1'b1;
      tick(4);
   endtask

   task automatic idle(input int k);
      repeat (k) send_word(1'b0, '0);
   endtask

   task automatic expect_word(input bit err, input bit eop, input bit sop, input logic [DATA_W-1:0] d);
      rx_entry_t e;
      e.err  = err;
      e.eop  = eop;
      e.sop  = sop;
      e.data = d;
      sb.push_back(e);
   endtask

   // Full packet from pl; cap = words the stalled FIFO can hold (16 when the consumer keeps up).
   task automatic send_pkt(input logic [7:0] seq, input bit bad_crc, input int cap);
      int                n;
      logic [DATA_W-1:0] x;
      bit                err;
      n = pl.size();
      x = '0;
      foreach (pl[i]) x ^= pl[i];
      err = bad_crc || (exp_ref_vld && seq != exp_ref + 8'd1);
      for (int i = 0; i < n && i < cap; i++)
         expect_word((i == n - 1) && err, i == n - 1, i == 0, pl[i]);
      if (err || n > cap) exp_err++;
      else                exp_pkt++;
      exp_ref     = seq;
      exp_ref_vld = 1'b1;
      send_word(1'b1, {HDR_MARKER, seq, 8'(n)});
      foreach (pl[i]) send_word(1'b1, pl[i]);
      send_word(1'b1, bad_crc ? (x ^ 18'h1) : x);
      pl.delete();
   endtask

   // Packet that announces decl_len words but stops after pl.size() of them.
   task automatic send_short(input logic [7:0] seq, input logic [7:0] decl_len);
      int n;
      n = pl.size();
      for (int i = 0; i < n; i++) expect_word(i == n - 1, i == n - 1, i == 0, pl[i]);
      exp_err++;
      send_word(1'b1, {HDR_MARKER, seq, decl_len});
      foreach (pl[i]) send_word(1'b1, pl[i]);
      send_word(1'b0, '0);
      pl.delete();
   endtask

   task automatic check_status(input string tag, input logic [5:0] flags, input int pkt, input int err);
      check({tag, "_flags"}, {hdr_err, seq_err, crc_err, len_err, gap_err, ovf_err}, flags);
      check({tag, "_pkt_cnt"}, pkt_cnt, pkt);
      check({tag, "_err_cnt"}, err_cnt, err);
   endtask

   task automatic clr();
      status_clr = 1'b1;
      tick(1);
      status_clr = 1'b0;
      tick(1);
      exp_pkt = 0;
      exp_err = 0;
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while (sb.size() != 0 && t < 4000) begin
         tick(1);
         t++;
      end
      check({tag, "_drain"}, sb.size(), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      rx_en          = 1'b1;
      status_clr     = 1'b0;
      cfg_idle_len   = 8'd10;
      adc_clk_rd     = 1'b0;
      adc_data       = '0;
      adc_data_valid = 1'b0;
      out_if.ready   = 1'b1;
      tick(5);
      check("rst_valid", out_if.valid, 0);
      check("rst_data", out_if.data, 0);
      check("rst_busy", busy, 0);
      check_status("rst", 6'b000000, 0, 0);
      rst = 1'b0;
      tick(2);
      idle(2);

      // Good packet.
      pl = '{18'h00001, 18'h00002, 18'h00004, 18'h00008};
      send_pkt(8'h05, 1'b0, 16);
      idle(12);
      wait_drain("good");
      check_status("good", 6'b000000, exp_pkt, exp_err);
      check("good_pkt_abs", pkt_cnt, 1);
      clr();

      // Bad trailer.
      pl = '{18'h00001, 18'h00002, 18'h00004, 18'h00008};
      send_pkt(8'h06, 1'b1, 16);
      idle(12);
      wait_drain("crc");
      check_status("crc", 6'b001000, exp_pkt, exp_err);
      check("crc_err_abs", err_cnt, 1);
      clr();

      // Sequence jump 7 -> 9, then 10 is accepted.
      pl = '{18'h00070, 18'h3FFFF};
      send_pkt(8'h07, 1'b0, 16);
      idle(12);
      pl = '{18'h12345, 18'h00900, 18'h20001};
      send_pkt(8'h09, 1'b0, 16);
      idle(12);
      check_status("seq", 6'b010000, exp_pkt, exp_err);
      pl = '{18'h0AAAA};
      send_pkt(8'h0A, 1'b0, 16);
      idle(12);
      wait_drain("seq");
      check_status("seq_next", 6'b010000, exp_pkt, exp_err);
      clr();

      // Short packet, then a clean one after the gap.
      pl = '{18'h0003A, 18'h0003B};
      send_short(8'h0B, 8'd4);
      idle(12);
      pl = '{18'h15555, 18'h2AAAA, 18'h00100};
      send_pkt(8'h0B, 1'b0, 16);
      idle(12);
      wait_drain("len");
      check_status("len", 6'b000100, exp_pkt, exp_err);
      clr();

      // Header after only 3 idle strobes: flagged but still accepted.
      pl = '{18'h00C01, 18'h00C02};
      send_pkt(8'h0C, 1'b0, 16);
      idle(3);
      pl = '{18'h00D01, 18'h00D02, 18'h00D03};
      send_pkt(8'h0D, 1'b0, 16);
      idle(12);
      wait_drain("gap");
      check_status("gap", 6'b000010, exp_pkt, exp_err);
      clr();
      check_status("clr", 6'b000000, 0, 0);

      // Bad headers: zero length, then wrong marker.
      send_word(1'b1, {HDR_MARKER, 8'h20, 8'h00});
      idle(12);
      check_status("hdr_len0", 6'b100000, 0, 1);
      clr();
      send_word(1'b1, {2'b01, 16'h1234});
      idle(12);
      check_status("hdr_marker", 6'b100000, 0, 1);
      check("hdr_idle", busy, 0);
      clr();

      // 20-word packet against a stalled consumer.
      out_if.ready = 1'b0;
      for (int i = 0; i < 20; i++) pl.push_back(DATA_W'(i * 3 + 1));
      send_pkt(8'h0E, 1'b0, 16);
      idle(12);
      check("ovf_held", out_if.valid, 1);
      check("ovf_sb_level", sb.size(), 16);
      check_status("ovf", 6'b000001, exp_pkt, exp_err);
      out_if.ready = 1'b1;
      wait_drain("ovf");
      tick(2);
      check("ovf_empty", out_if.valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_pkt_rx.md
Name: adc_pkt_rx

Overview:
- Far-end receiver for the ASIC's ADC capture pad interface: PAD1..18 ADC_DATA, PAD19 ADC_DATA_VALID and PAD21 CLK_RD.
- Oversamples CLK_RD in its own clock domain, de-frames packets emitted by the packet controller, and checks each packet's header, sequence number, length, trailer XOR and idle gap.
- Delivers payload words through a FIFO with valid/ready handshake.
- Used in the FPGA capture board and as the bench-side checker in ASIC-level simulation.

Parameters:
- DATA_W, 18, pad data width.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4).
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  in  1  receiver clock; must be >=4x CLK_RD.
- rst  in  1  synchronous, active-high reset.
- rx_en  in  1  receiver enable.
- cfg_idle_len  in  8  minimum idle gap between packets, in CLK_RD periods.
- status_clr  in  1  one-cycle pulse; clears counters and sticky flags.
- adc_clk_rd  in  1  PAD21_CLK_RD, asynchronous to clk.
- adc_data  in  DATA_W  PAD1..18 data.
- adc_data_valid  in  1  PAD19 valid.
- out_data  out  DATA_W  payload word.
- out_sop  out  1  first payload word of a packet.
- out_eop  out  1  last payload word of a packet.
- out_err  out  1  packet failed a check; valid only with out_eop.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts the word.
- pkt_cnt  out  CNT_W  good packets received; wraps.
- err_cnt  out  CNT_W  bad packets; saturates.
- hdr_err, seq_err, crc_err, len_err, gap_err, ovf_err  out  1 each  sticky error flags.
- busy  out  1  FSM is not in IDLE.

Behaviour:
Reset
- All outputs are 0.
- FIFO is empty.
- FSM is in IDLE.
- Sequence reference is invalid.

Input synchronisation and strobe
- adc_clk_rd, adc_data and adc_data_valid each pass through a 2-flop synchroniser.
- Detect a rising edge of the synchronised clk_rd.
- The strobe is a 1-clk pulse, asserted 3 clk after the pad edge.
- On the strobe, sample the synchronised data and valid. The transmitter launches on the falling edge.

Frame format
- Header word: [17:16]=2'b10, [15:8]=seq, [7:0]=len N, with N in 1..255.
- Followed by N payload words, all with valid=1.
- Followed by one trailer word equal to the 18-bit XOR of all N payload words.
- Followed by at least cfg_idle_len strobes with valid=0.

FSM (advances only on strobe)
- IDLE:
  - valid=1 and marker=10 and N!=0: latch seq and N, clear the XOR accumulator, go to PAYLOAD.
  - valid=1 with any other header: set hdr_err, err_cnt+1, go to GAP.
- PAYLOAD:
  - Each valid word updates the XOR and is held in a 1-word skid register.
  - The previously held word, if any, is pushed to the FIFO. sop=1 on the first pushed word.
  - After N words, go to TRAILER.
  - valid=0 before N words: set len_err, push the held word with eop=1 and err=1, go to GAP.
- TRAILER:
  - valid=1: push the held word with eop=1 and err=(trailer!=XOR). A mismatch sets crc_err.
  - Sequence check: if the reference is valid and seq != ref+1 (mod 256), set seq_err and err=1. Then ref=seq and the reference becomes valid.
  - Go to GAP.
  - valid=0: handled as the len_err case.
- GAP:
  - Count valid=0 strobes.
  - Reaching cfg_idle_len: go to IDLE.
  - valid=1 earlier: set gap_err, treat the word as a header (same rules as IDLE).
  - cfg_idle_len=0 means GAP exits immediately.

Counters and sticky flags
- Every eop push with err=0 increments pkt_cnt.
- err=1 increments err_cnt, saturating.
- Sticky flags stay set until status_clr or rst.
- status_clr takes priority over a same-cycle set.

FIFO
- First-word fall-through. Entry = {err, eop, sop, data}.
- Transfer occurs when out_valid && out_ready.
- A push and a pop in the same cycle are both allowed, including when the FIFO is full.
- A push while full (with no pop) drops the word and sets ovf_err.
- The packet's eop entry is forced to err=1.
- If the eop entry itself is dropped, err_cnt still increments.

Enable and reset mid-operation
- rx_en=0: the FSM goes to IDLE on the next clk and the skid word is discarded. The FIFO keeps its contents and still drains.
- The sequence reference becomes invalid on rx_en falling.
- rst mid-packet: full reset; no partial eop is emitted.

Latency
- Pad edge to strobe: 3 clk.
- Strobe to FIFO write: 1 clk.
- FIFO write to out_valid: 1 clk.

Decomposition:
- Package adc_pkt_pkg holds:
  - DATA_W
  - HDR_MARKER=2'b10
  - state enum {IDLE, PAYLOAD, TRAILER, GAP}
  - packed struct rx_entry_t {err, eop, sop, data}
- Sub-module adc_pkt_rx_fifo: synchronous FWFT FIFO parameterised by depth and entry type.
- Synchroniser, strobe generation, FSM and checks live in the top module.

Test Plan:
- Good packet: clk_rd=clk/8, cfg_idle_len=10. Header seq=0x05 len=4, payload 0x00001/0x00002/0x00004/0x00008, trailer 0x0000F -> 4 words out, sop on word 1, eop on word 4, err=0, pkt_cnt=1.
- Trailer 0x0000E on the same packet -> eop word has err=1, crc_err=1, err_cnt=1, pkt_cnt=0.
- Packets with seq 7 then 9 -> second eop has err=1, seq_err=1. A following seq 10 gives err=0.
- len=4 but valid drops after word 2 -> len_err=1, word 2 emitted with eop=1 err=1. The next good packet after the idle gap is received cleanly.
- Next header arrives after 3 idle strobes with cfg_idle_len=10 -> gap_err=1 and the packet is still accepted. status_clr then clears all flags and counters.
- out_ready=0 for a 20-word packet, FIFO_DEPTH=16 -> ovf_err=1, 16 words buffered, eop err=1. Releasing out_ready drains them in order.
